// File: rtl/apb_sample_fifo_completer_if.sv
// APB3 completer-side bus bundle for the sample FIFO; master drives request, slave drives response.
interface apb_sample_fifo_completer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_sample_fifo_completer.sv
// APB sample FIFO: zero-wait register access, one wait state per DATA pop; pushes drop (OVF) when full.
// Optional SAMPLE_FIFO_TIMESTAMP_EN stores a 15-bit cycle stamp per entry, returned in DATA[30:16].
module apb_sample_fifo_completer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 12,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    apb_sample_fifo_completer_if.slave    apb,
    input  logic                          sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]       sample_data,
    output logic                          irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef SAMPLE_FIFO_TIMESTAMP_EN
    localparam int EW = SAMPLE_WIDTH + 15;
`else
    localparam int EW = SAMPLE_WIDTH;
`endif
    localparam logic [8:0] DEPTH_C = 9'(FIFO_DEPTH);
    localparam logic [1:0] SEL_CTRL = 2'd0, SEL_STATUS = 2'd1, SEL_DATA = 2'd2, SEL_THRESH = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [8:0]        count;
    logic [8:0]        thresh;
    logic              en, irq_en, ovf;
    logic [31:0]       rdata_q;
    logic [EW-1:0]     push_entry;

    logic              access, addr_ok, slv_err, data_rd;
    logic [1:0]        reg_sel;
    logic              ready, err, reg_wr, pop_req;
    logic [31:0]       rdata, reg_rdata;
    logic              full, empty, pop, push_try, push, flush, ovf_set;
    logic              unused_ok;

    function automatic logic [31:0] entry_word(input logic [EW-1:0] e);
        logic [31:0] w;
        w = 32'(e[SAMPLE_WIDTH-1:0]);
`ifdef SAMPLE_FIFO_TIMESTAMP_EN
        w[30:16] = e[EW-1:SAMPLE_WIDTH];
`endif
        return w;
    endfunction

`ifdef SAMPLE_FIFO_TIMESTAMP_EN
    logic [14:0] ts;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) ts <= '0;
        else        ts <= ts + 15'd1;
    end
    assign push_entry = {ts, sample_data};
`else
    assign push_entry = sample_data;
`endif

    assign access  = apb.PSEL & apb.PENABLE;
    assign reg_sel = apb.PADDR[3:2];
    assign addr_ok = (apb.PADDR[ADDR_WIDTH-1:4] == '0) && (apb.PADDR[1:0] == 2'b00);
    assign slv_err = !addr_ok || (apb.PWRITE && (reg_sel == SEL_STATUS || reg_sel == SEL_DATA));
    assign data_rd = addr_ok && !apb.PWRITE && (reg_sel == SEL_DATA);

    assign full  = (count == DEPTH_C);
    assign empty = (count == 9'd0);

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            SEL_CTRL:   reg_rdata = {30'd0, irq_en, en};
            SEL_STATUS: reg_rdata = {13'd0, ovf, full, empty, 7'd0, count};
            SEL_THRESH: reg_rdata = {23'd0, thresh};
            default:    reg_rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        reg_wr    = 1'b0;
        pop_req   = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (data_rd) begin
                        state_nxt = WAIT;
                        pop_req   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        ready     = 1'b1;
                        if (slv_err)           err    = 1'b1;
                        else if (apb.PWRITE)   reg_wr = 1'b1;
                        else                   rdata  = reg_rdata;
                    end
                end
            end
            WAIT: begin
                // Dropping PSEL here abandons the read; the pop already happened.
                if (apb.PSEL) begin
                    ready     = 1'b1;
                    rdata     = rdata_q;
                    state_nxt = DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (!apb.PENABLE || !apb.PSEL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign apb.PREADY  = ready & ~PRESET;
    assign apb.PSLVERR = err & ~PRESET;
    assign apb.PRDATA  = PRESET ? '0 : DATA_WIDTH'(rdata);

    assign pop      = pop_req & ~empty;
    assign flush    = reg_wr && (reg_sel == SEL_CTRL) && apb.PWDATA[2];
    assign push_try = sample_valid & en;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign push     = push_try & (~full | pop) & ~flush;
    assign ovf_set  = push_try & full & ~pop & ~flush;

    always_ff @(posedge PCLK) begin
        if (push) mem[wptr] <= push_entry;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            thresh  <= '0;
            rdata_q <= '0;
            irq     <= 1'b0;
        end else begin
            if (pop_req) rdata_q <= empty ? 32'h8000_0000 : entry_word(mem[rptr]);

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + PW'(1);
                if (pop)  rptr <= rptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + 9'd1;
                    2'b01:   count <= count - 9'd1;
                    default: count <= count;
                endcase
            end

            if (reg_wr && reg_sel == SEL_CTRL) begin
                en     <= apb.PWDATA[0];
                irq_en <= apb.PWDATA[1];
            end
            if (reg_wr && reg_sel == SEL_THRESH) thresh <= apb.PWDATA[8:0];

            if (ovf_set)                                             ovf <= 1'b1;
            else if (reg_wr && reg_sel == SEL_CTRL && apb.PWDATA[3]) ovf <= 1'b0;

            irq <= irq_en & (((thresh != 9'd0) && (count >= thresh)) | ovf);
        end
    end

    assign unused_ok = ^apb.PWDATA[DATA_WIDTH-1:9];
endmodule

// File: tb/tb_apb_sample_fifo_completer.sv
// Directed plus randomized bench for apb_sample_fifo_completer against a queue-based reference model.
module tb_apb_sample_fifo_completer;
    localparam int DEPTH = 16;
`ifdef SAMPLE_FIFO_TIMESTAMP_EN
    localparam logic [31:0] DMASK = 32'h8000_FFFF;
`else
    localparam logic [31:0] DMASK = 32'hFFFF_FFFF;
`endif

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        irq;
    int          checks;
    int          errors;

    apb_sample_fifo_completer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    apb_sample_fifo_completer #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .SAMPLE_WIDTH(12), .FIFO_DEPTH(DEPTH)
    ) dut (
        .PCLK(clk), .PRESET(rst), .apb(bus),
        .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: register file plus a plain queue of samples.
    int unsigned q[$];
    bit          m_en, m_irq_en, m_ovf;
    int unsigned m_thresh;

    function automatic void m_reset();
        q.delete();
        m_en = 0; m_irq_en = 0; m_ovf = 0; m_thresh = 0;
    endfunction

    function automatic void m_push(input int unsigned d);
        if (m_en) begin
            if (q.size() == DEPTH) m_ovf = 1;
            else                   q.push_back(d);
        end
    endfunction

    function automatic logic [31:0] m_pop();
        if (q.size() == 0) return 32'h8000_0000;
        return 32'(q.pop_front());
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(q.size());
        s[16] = (q.size() == 0);
        s[17] = (q.size() == DEPTH);
        s[18] = m_ovf;
        return s;
    endfunction

    function automatic logic m_irq();
        return m_irq_en && ((m_thresh != 0 && q.size() >= m_thresh) || m_ovf);
    endfunction

    function automatic void m_ctrl(input logic [3:0] v);
        m_en     = v[0];
        m_irq_en = v[1];
        if (v[2]) q.delete();
        if (v[3]) m_ovf = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                            input logic sv, input logic [11:0] sd,
                            output logic [31:0] rd, output logic err, output int waits,
                            output logic irq_rdy);
        bit done;
        done = 0; waits = 0; rd = '0; err = 0; irq_rdy = 0;
        @(posedge clk); #1;
        bus.PSEL = 1; bus.PADDR = addr; bus.PWRITE = wr; bus.PWDATA = wd; bus.PENABLE = 0;
        @(posedge clk); #1;
        bus.PENABLE = 1;
        if (sv) begin sample_valid = 1; sample_data = sd; end
        while (!done) begin
            @(negedge clk);
            if (bus.PREADY === 1'b1) begin
                rd = bus.PRDATA; err = bus.PSLVERR; irq_rdy = irq; done = 1;
            end else begin
                waits++;
                if (waits > 8) begin
                    checks++; errors++;
                    $error("FAIL pready_timeout: waited %0d cycles, required PREADY=1 within 8", waits);
                    done = 1;
                end
            end
            @(posedge clk); #1;
            sample_valid = 0;
        end
        bus.PSEL = 0; bus.PENABLE = 0;
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [31:0] rd, output logic err, output int w);
        logic ir;
        apb_xfer(1'b0, a, 32'd0, 1'b0, 12'd0, rd, err, w, ir);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d, output logic err, output int w);
        logic [31:0] rd;
        logic ir;
        apb_xfer(1'b1, a, d, 1'b0, 12'd0, rd, err, w, ir);
    endtask

    task automatic push(input logic [11:0] d);
        @(posedge clk); #1;
        sample_valid = 1; sample_data = d;
        @(posedge clk); #1;
        sample_valid = 0;
        m_push(d);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err, ir;
        int          w;
        logic [11:0] v;
        int          op;
        logic [3:0]  cv;

        checks = 0; errors = 0;
        m_reset();
        rst = 1; sample_valid = 0; sample_data = '0;
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 0;

        rd_reg(16'h4, rd, err, w);
        chk("status_reset", rd, 32'h0001_0000);
        chk("status_waits", 32'(w), 32'd0);
        chk("status_err", 32'(err), 32'd0);
        chk("status_irq", 32'(irq), 32'd0);

        wr_reg(16'h0, 32'h1, err, w); m_ctrl(4'h1);
        push(12'h123); push(12'hABC);
        rd_reg(16'h8, rd, err, w);
        chk("data0", rd & DMASK, m_pop());
        chk("data0_waits", 32'(w), 32'd1);
        rd_reg(16'h8, rd, err, w);
        chk("data1", rd & DMASK, m_pop());
        chk("data1_waits", 32'(w), 32'd1);
        rd_reg(16'h8, rd, err, w);
        chk("data_empty", rd, 32'h8000_0000);

        for (int i = 0; i < 17; i++) push(12'($urandom));
        rd_reg(16'h4, rd, err, w);
        chk("status_full_ovf", rd, 32'h0006_0010);
        wr_reg(16'h0, 32'h9, err, w); m_ctrl(4'h9);
        rd_reg(16'h4, rd, err, w);
        chk("status_ovf_clr", rd, 32'h0002_0010);
        wr_reg(16'h0, 32'h5, err, w); m_ctrl(4'h5);
        rd_reg(16'h4, rd, err, w);
        chk("status_flush", rd, 32'h0001_0000);
        rd_reg(16'h0, rd, err, w);
        chk("ctrl_readback", rd, 32'h1);

        wr_reg(16'hC, 32'h4, err, w); m_thresh = 4;
        wr_reg(16'h0, 32'h3, err, w); m_ctrl(4'h3);
        for (int i = 0; i < 3; i++) push(12'($urandom));
        @(posedge clk); #1;
        chk("irq_below_thresh", 32'(irq), 32'd0);
        push(12'h444);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_rise", 32'(irq), 32'd1);
        apb_xfer(1'b0, 16'h8, 32'd0, 1'b0, 12'd0, rd, err, w, ir);
        chk("irq_pop_data", rd & DMASK, m_pop());
        chk("irq_held_in_wait", 32'(ir), 32'd1);
        chk("irq_fall", 32'(irq), 32'd0);

        wr_reg(16'h0, 32'h5, err, w); m_ctrl(4'h5);
        for (int i = 0; i < DEPTH; i++) push(12'($urandom));
        v = 12'h5A5;
        apb_xfer(1'b0, 16'h8, 32'd0, 1'b1, v, rd, err, w, ir);
        chk("simul_pop", rd & DMASK, m_pop());
        m_push(v);
        rd_reg(16'h4, rd, err, w);
        chk("simul_status", rd, 32'h0002_0010);
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(16'h8, rd, err, w);
            chk("simul_drain", rd & DMASK, m_pop());
        end
        chk("simul_last_is_new", rd & DMASK, 32'(v));

        wr_reg(16'h4, 32'hFFFF_FFFF, err, w);
        chk("wr_status_err", 32'(err), 32'd1);
        chk("wr_status_waits", 32'(w), 32'd0);
        wr_reg(16'h8, 32'h1, err, w);
        chk("wr_data_err", 32'(err), 32'd1);
        rd_reg(16'h10, rd, err, w);
        chk("rd_0x10_err", 32'(err), 32'd1);
        chk("rd_0x10_data", rd, 32'd0);
        wr_reg(16'hE, 32'h1FF, err, w);
        chk("wr_misaligned_err", 32'(err), 32'd1);
        rd_reg(16'hC, rd, err, w);
        chk("thresh_unchanged", rd, 32'(m_thresh));
        rd_reg(16'h4, rd, err, w);
        chk("status_unchanged", rd, m_status());

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 10);
            if (op <= 3) begin
                push(12'($urandom));
            end else if (op <= 5) begin
                rd_reg(16'h8, rd, err, w);
                chk("rnd_data", rd & DMASK, m_pop());
            end else if (op == 6) begin
                rd_reg(16'h4, rd, err, w);
                chk("rnd_status", rd, m_status());
            end else if (op == 7) begin
                m_thresh = $urandom_range(0, 20);
                wr_reg(16'hC, 32'(m_thresh), err, w);
            end else if (op == 8) begin
                cv = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) cv[0] = 1'b1;
                wr_reg(16'h0, 32'(cv), err, w);
                m_ctrl(cv);
            end else if (op == 9) begin
                rd_reg(16'h0, rd, err, w);
                chk("rnd_ctrl", rd, {30'd0, m_irq_en, m_en});
            end else begin
                rd_reg(16'hC, rd, err, w);
                chk("rnd_thresh", rd, 32'(m_thresh));
            end
            @(posedge clk); #1;
            chk("rnd_irq", 32'(irq), 32'(m_irq()));
        end

        wr_reg(16'h0, 32'h5, err, w); m_ctrl(4'h5);
        push(12'h111); push(12'h222);
        @(posedge clk); #1;
        bus.PSEL = 1; bus.PADDR = 16'h8; bus.PWRITE = 0; bus.PENABLE = 0;
        @(posedge clk); #1;
        bus.PENABLE = 1;
        @(negedge clk);
        chk("wait_pready_low", 32'(bus.PREADY), 32'd0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_wait_pready", 32'(bus.PREADY), 32'd0);
        chk("rst_wait_prdata", bus.PRDATA, 32'd0);
        bus.PSEL = 0; bus.PENABLE = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_reset();
        rd_reg(16'h4, rd, err, w);
        chk("rst_wait_status", rd, 32'h0001_0000);
        rd_reg(16'h8, rd, err, w);
        chk("rst_wait_data", rd, 32'h8000_0000);
        rd_reg(16'h0, rd, err, w);
        chk("rst_wait_ctrl", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
